bitty_fetch: RTL and testbench

- Instruction sequencer that drives the bitty core controller from the initiator side.
- Owns the program counter and reads 16-bit instructions from instruction memory.
- Presents each instruction with a one-cycle run pulse, waits for the controller's done, then advances the PC or takes a branch.
- Sits between the instruction ROM/RAM and the cpu controller block; the cpu consumes run/d_inst and returns done.

---
 rtl/bitty_pkg.sv | 33 +++
 rtl/bitty_branch_eval.sv | 28 ++
 rtl/bitty_fetch.sv | 113 +++++++++++
 tb/tb_bitty_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared encodings for the bitty fetch sequencer: instruction formats,
// branch conditions, compare results and the fetch FSM states.
package bitty_pkg;

  localparam logic [1:0] FMT_REG  = 2'b00;
  localparam logic [1:0] FMT_IMM  = 2'b01;
  localparam logic [1:0] FMT_BR   = 2'b10;

  localparam logic [1:0] BR_EQ    = 2'b00;
  localparam logic [1:0] BR_GT    = 2'b01;
  localparam logic [1:0] BR_LT    = 2'b10;
  localparam logic [1:0] BR_NEVER = 2'b11;

  localparam logic [1:0] CMP_EQ   = 2'b00;
  localparam logic [1:0] CMP_GT   = 2'b01;
  localparam logic [1:0] CMP_LT   = 2'b10;
  localparam logic [1:0] CMP_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4
  } fetch_state_e;

  // Condition codes line up with compare codes, so a match is equality,
  // except that the "never" code must not match a "none" compare.
  function automatic logic br_cond_met(input logic [1:0] cond, input logic [1:0] cmp_res);
    return (cond != BR_NEVER) && (cond == cmp_res);
  endfunction

endpackage

// File: rtl/bitty_branch_eval.sv
// Combinational next-PC selection: branch target when a branch condition
// holds, otherwise the sequential PC.
module bitty_branch_eval
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [15:0]       d_inst,
  input  logic [1:0]        cmp,
  input  logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic [ADDR_W-1:0] next_pc
);

  logic [11:0] w_target_field;

  assign w_target_field = d_inst[15:4];

  always_comb begin
    taken = (d_inst[1:0] == FMT_BR) && br_cond_met(d_inst[3:2], cmp);
    if (taken) begin
      next_pc = w_target_field[ADDR_W-1:0];
    end else begin
      next_pc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction sequencer: fetches from instruction memory, issues a run pulse
// to the cpu controller, waits for done, then advances or branches.
module bitty_fetch
  import bitty_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  input  logic              mem_valid,
  output logic              run,
  output logic [15:0]       d_inst,
  input  logic              done,
  input  logic [1:0]        cmp,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_inst;
  logic              r_run;
  logic              r_mem_rd;
  logic              r_halted;
  logic              r_stop_pend;

  logic              w_taken;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_halt;

  bitty_branch_eval #(.ADDR_W(ADDR_W)) u_branch_eval (
    .d_inst  (r_inst),
    .cmp     (cmp),
    .pc      (r_pc),
    .taken   (w_taken),
    .next_pc (w_next_pc)
  );

  assign w_halt   = r_stop_pend || (!w_taken && (r_pc == END_ADDR));
  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign mem_rd   = r_mem_rd;
  assign run      = r_run;
  assign d_inst   = r_inst;
  assign halted   = r_halted;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_inst      <= 16'h0000;
      r_run       <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_halted    <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_run <= 1'b0;
      if (stop && (r_state != IDLE)) begin
        r_stop_pend <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            r_mem_rd <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_valid) begin
            r_inst   <= mem_data;
            r_mem_rd <= 1'b0;
            r_run    <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            r_state <= NEXT;
          end
        end
        NEXT: begin
          // A stop arriving in this very cycle applies to the next instruction.
          r_pc        <= w_next_pc;
          r_stop_pend <= stop;
          if (w_halt) begin
            r_state  <= IDLE;
            r_halted <= 1'b1;
          end else begin
            r_state  <= FETCH;
            r_mem_rd <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_fetch.sv
// Self-checking bench for bitty_fetch: memory and cpu responders driven from
// the bench, with an instruction-level reference model of PC sequencing.
module tb_bitty_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        run;
  logic [15:0] d_inst;
  logic        done;
  logic [1:0]  cmp;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [256];
  logic [7:0]  model_pc;
  bit          model_pend;
  bit          model_halted;

  bitty_fetch #(.ADDR_W(8), .END_ADDR(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .run       (run),
    .d_inst    (d_inst),
    .done      (done),
    .cmp       (cmp),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},     pc,     32'd0);
    check({tag, "_addr"},   mem_addr, 32'd0);
    check({tag, "_dinst"},  d_inst, 32'd0);
    check({tag, "_run"},    run,    32'd0);
    check({tag, "_rd"},     mem_rd, 32'd0);
    check({tag, "_busy"},   busy,   32'd0);
    check({tag, "_halted"}, halted, 32'd0);
  endtask

  task automatic do_start(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    model_halted = 1'b0;
    check("start_busy", busy, 32'd1);
    check("start_halted", halted, 32'd0);
  endtask

  // Executes one instruction from the FETCH negedge to the negedge after NEXT.
  task automatic run_one(input logic [1:0] c, input bit do_stop, input int lat, input int dl);
    logic [15:0] inst;
    logic [7:0]  exp_next;
    bit          tk;
    bit          hlt;
    inst = mem[model_pc];
    check("fetch_rd", mem_rd, 32'd1);
    check("fetch_addr", mem_addr, {24'd0, model_pc});
    for (int i = 1; i < lat; i++) begin
      done = (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      done = 1'b0;
      check("rd_hold", mem_rd, 32'd1);
      check("run_quiet_fetch", run, 32'd0);
    end
    mem_data  = inst;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_data  = 16'($urandom);
    check("run_pulse", run, 32'd1);
    check("d_inst", d_inst, {16'd0, inst});
    check("rd_drop", mem_rd, 32'd0);
    check("pc_hold", pc, {24'd0, model_pc});
    @(negedge clk);
    for (int i = 0; i < dl; i++) begin
      check("run_single", run, 32'd0);
      check("d_inst_hold", d_inst, {16'd0, inst});
      check("rd_quiet_wait", mem_rd, 32'd0);
      if (do_stop && i == 0) begin
        stop = 1'b1;
        model_pend = 1'b1;
      end
      if (i == 1) begin
        mem_valid = 1'b1;
      end
      @(negedge clk);
      stop      = 1'b0;
      mem_valid = 1'b0;
    end
    cmp  = c;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("d_inst_next", d_inst, {16'd0, inst});
    check("run_quiet_next", run, 32'd0);
    @(negedge clk);
    tk = (inst[1:0] == 2'b10) && (inst[3:2] != 2'b11) && (inst[3:2] == c);
    exp_next = tk ? inst[11:4] : model_pc + 8'd1;
    hlt = model_pend || (!tk && model_pc == 8'hFF);
    model_pend   = 1'b0;
    model_pc     = exp_next;
    model_halted = hlt;
    check("next_pc", pc, {24'd0, model_pc});
    check("next_busy", busy, {31'd0, !hlt});
    check("next_halted", halted, {31'd0, hlt});
    check("next_rd", mem_rd, {31'd0, !hlt});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    mem_data = 16'h0000;
    mem_valid = 1'b0;
    done = 1'b0;
    cmp = 2'b11;
    model_pc = 8'd0;
    model_pend = 1'b0;
    model_halted = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {14'($urandom), 2'b01};
    end
    mem[0]   = 16'h2001;
    mem[1]   = 16'h4000;
    mem[2]   = 16'h1234;
    mem[5]   = 16'h0032;
    mem[6]   = 16'h0FE2;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_rst");

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", busy, 32'd0);
    check("idle_stop_rd", mem_rd, 32'd0);

    do_start(1'b0);
    run_one(2'b00, 1'b0, 1, 3);
    run_one(2'b00, 1'b0, 1, 3);
    run_one(2'b00, 1'b1, 4, 7);
    check("stop_pc3", pc, 32'd3);
    repeat (2) @(negedge clk);
    check("stop_no_rd", mem_rd, 32'd0);

    do_start(1'b1);
    run_one(2'b11, 1'b0, 1, 3);
    run_one(2'b11, 1'b0, 2, 3);
    run_one(2'b00, 1'b0, 1, 3);
    check("br_eq_target", mem_addr, 32'd3);
    run_one(2'b11, 1'b0, 1, 3);
    run_one(2'b11, 1'b0, 1, 3);
    run_one(2'b01, 1'b0, 3, 2);
    check("br_gt_fall", mem_addr, 32'd6);
    run_one(2'b00, 1'b0, 1, 3);
    check("br_far", mem_addr, 32'hFE);
    run_one(2'b10, 1'b0, 1, 3);
    run_one(2'b10, 1'b0, 1, 3);
    check("end_halted", halted, 32'd1);
    check("end_pc_wrap", pc, 32'd0);
    do_start(1'b0);
    run_one(2'b11, 1'b0, 1, 3);

    // Reset while the cpu is working on pc 1.
    mem_data = mem[1];
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_idle_busy", busy, 32'd0);
      check("rst_idle_rd", mem_rd, 32'd0);
      check("rst_idle_pc", pc, 32'd0);
    end
    model_pc = 8'd0;
    model_pend = 1'b0;
    model_halted = 1'b1;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
    end
    for (int n = 0; n < 200; n++) begin
      if (model_halted) begin
        do_start(1'($urandom_range(0, 1)));
      end
      run_one(2'($urandom), ($urandom_range(0, 9) == 0), int'($urandom_range(1, 5)),
              int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
